// File: rtl/datapath_lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states, lane-bit helper.
package datapath_lsu_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 10;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_DONE = 2'd2;
    localparam state_t ST_ERR  = 2'd3;

    // Number of byte-lane address bits for a given datapath width.
    function automatic int lb(input int dw);
        return (dw == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/datapath_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface datapath_lsu_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    localparam int NB = DW / 8;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [NB-1:0] mem_be;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/datapath_lsu_lane_align.sv
// Combinational lane logic: byte enables, store-data replication, load extraction/extension.
module lsu_lane_align
    import datapath_lsu_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [1:0]        size,
    input  logic [lb(DW)-1:0] lane,
    input  logic              sgn,
    input  logic [DW-1:0]     wdata,
    input  logic [DW-1:0]     rdata,
    output logic [DW/8-1:0]   be,
    output logic [DW-1:0]     wrep,
    output logic [DW-1:0]     rext
);
    localparam int NB = DW / 8;
    localparam logic [DW-1:0] M8  = DW'(8'hFF);
    localparam logic [DW-1:0] M16 = DW'(16'hFFFF);
    localparam logic [DW-1:0] M32 = DW'(32'hFFFF_FFFF);

    logic [DW-1:0] sh;
    logic [DW-1:0] msk;
    logic          msb;

    assign sh = rdata >> {lane, 3'b000};

    always_comb begin
        be   = '1;
        wrep = wdata;
        msk  = '1;
        msb  = 1'b0;
        case (size)
            SZ_B: begin
                be   = NB'(1) << lane;
                wrep = {NB{wdata[7:0]}};
                msk  = M8;
                msb  = sh[7];
            end
            SZ_H: begin
                be   = NB'(3) << lane;
                wrep = {(DW/16){wdata[15:0]}};
                msk  = M16;
                msb  = sh[15];
            end
            SZ_W: begin
                be   = NB'(15) << lane;
                wrep = {(DW/32){wdata[31:0]}};
                msk  = M32;
                msb  = sh[31];
            end
            default: ;
        endcase
        // A full-width mask leaves the dword pass-through untouched.
        rext = (sgn && msb) ? (sh | ~msk) : (sh & msk);
    end

endmodule

// File: rtl/datapath_lsu.sv
// Load/store unit FSM with req/ack memory handshake and misalignment detection.
// Optional ack watchdog enabled by defining LSU_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on acceptance
// REQ     | memory request held until mem_ack (or watchdog expiry)
// DONE    | one-cycle completion pulse
// ERR     | one-cycle completion pulse with misalign, no memory access
module datapath_lsu
    import datapath_lsu_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sgn,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          misalign,
    output logic [DW-1:0] rdata,
`ifdef LSU_TIMEOUT_EN
    output logic          timeout,
`endif
    datapath_lsu_if.master mem
);
    localparam int LB = lb(DW);
    localparam int NB = DW / 8;

    state_t           state;
    logic             l_we;
    logic             l_sgn;
    logic [1:0]       l_size;
    logic [AW+LB-1:0] l_addr;
    logic [DW-1:0]    l_wdata;
    logic             legal;
    logic             to_hit;
    logic [NB-1:0]    be;
    logic [DW-1:0]    wrep;
    logic [DW-1:0]    rext;
    logic             unused_addr;

    assign unused_addr = ^addr[DW-1:AW+LB];

    always_comb begin
        legal = 1'b0;
        case (size)
            SZ_B:    legal = 1'b1;
            SZ_H:    legal = ~addr[0];
            SZ_W:    legal = (addr[1:0] == 2'b00);
            default: legal = (DW == 64) && (addr[2:0] == 3'b000);
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;

    assign to_hit = (state == ST_REQ) && !mem.mem_ack && (tcnt == TW'(TIMEOUT - 1));

    // Cleared outside REQ, so every new request starts counting from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= to_hit;
            if (state != ST_REQ)
                tcnt <= '0;
            else if (!mem.mem_ack)
                tcnt <= tcnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            l_we    <= 1'b0;
            l_sgn   <= 1'b0;
            l_size  <= SZ_B;
            l_addr  <= '0;
            l_wdata <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    l_we    <= we;
                    l_sgn   <= sgn;
                    l_size  <= size;
                    l_addr  <= addr[AW+LB-1:0];
                    l_wdata <= wdata;
                    state   <= legal ? ST_REQ : ST_ERR;
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        state <= ST_DONE;
                        if (!l_we)
                            rdata <= rext;
                    end else if (to_hit) begin
                        state <= ST_ERR;
                    end
                end
                ST_DONE, ST_ERR: state <= ST_IDLE;
            endcase
        end
    end

    lsu_lane_align #(.DW(DW)) u_align (
        .size  (l_size),
        .lane  (l_addr[LB-1:0]),
        .sgn   (l_sgn),
        .wdata (l_wdata),
        .rdata (mem.mem_rdata),
        .be    (be),
        .wrep  (wrep),
        .rext  (rext)
    );

    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE) || (state == ST_ERR);
    assign misalign      = (state == ST_ERR);
    assign mem.mem_req   = (state == ST_REQ);
    assign mem.mem_we    = (state == ST_REQ) && l_we;
    assign mem.mem_be    = (state == ST_REQ) ? be : '0;
    assign mem.mem_addr  = l_addr[AW+LB-1:LB];
    assign mem.mem_wdata = wrep;

endmodule

// File: tb/tb_datapath_lsu.sv
// Directed bench for datapath_lsu with an abstract reference model and per-cycle compare.
module tb_datapath_lsu;
    logic        clk;
    logic        rst;
    logic        start;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] rdata;

    datapath_lsu_if #(.DW(32), .AW(10)) mif ();

`ifdef LSU_TIMEOUT_EN
    logic timeout;
    datapath_lsu #(.DW(32), .AW(10), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .we(we), .size(size), .sgn(sgn),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .misalign(misalign),
        .rdata(rdata), .timeout(timeout), .mem(mif.master));
`else
    datapath_lsu #(.DW(32), .AW(10)) dut (
        .clk(clk), .rst(rst), .start(start), .we(we), .size(size), .sgn(sgn),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .misalign(misalign),
        .rdata(rdata), .mem(mif.master));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_load(input logic [1:0] s, input logic sg,
                                           input logic [31:0] a, input logic [31:0] d);
        int nbytes = 1 << s;
        int off = a % 4;
        logic [63:0] mask = (64'd1 << (8 * nbytes)) - 64'd1;
        logic [63:0] v = ({32'd0, d} >> (8 * off)) & mask;
        if (sg && v[8*nbytes-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] s, input logic [31:0] a);
        int nbytes = 1 << s;
        logic [7:0] b = 8'(((1 << nbytes) - 1) << (a % 4));
        return b[3:0];
    endfunction

    function automatic logic [31:0] m_wrep(input logic [1:0] s, input logic [31:0] wd);
        int nbytes = 1 << s;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        return r;
    endfunction

    function automatic bit m_legal(input logic [1:0] s, input logic [31:0] a);
        return (s != 2'd3) && ((a % (1 << s)) == 0);
    endfunction

    logic        m_req, m_done, m_mis, m_to;
    logic [31:0] m_rdata;
    int          m_wait;
    logic        o_we, o_sgn;
    logic [1:0]  o_size;
    logic [31:0] o_addr, o_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req <= 0; m_done <= 0; m_mis <= 0; m_to <= 0; m_rdata <= 0; m_wait <= 0;
        end else if (m_done) begin
            m_done <= 0; m_mis <= 0; m_to <= 0;
        end else if (m_req) begin
            if (mif.mem_ack) begin
                m_req <= 0; m_done <= 1;
                if (!o_we) m_rdata <= m_load(o_size, o_sgn, o_addr, mif.mem_rdata);
            end
`ifdef LSU_TIMEOUT_EN
            else if (m_wait + 1 == 4) begin
                m_req <= 0; m_done <= 1; m_mis <= 1; m_to <= 1;
            end else m_wait <= m_wait + 1;
`endif
        end else if (start) begin
            o_we <= we; o_sgn <= sgn; o_size <= size; o_addr <= addr; o_wdata <= wdata;
            m_wait <= 0;
            if (m_legal(size, addr)) m_req <= 1;
            else begin m_done <= 1; m_mis <= 1; end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("busy", {63'd0, busy}, {63'd0, m_req | m_done});
            chk("done", {63'd0, done}, {63'd0, m_done});
            chk("misalign", {63'd0, misalign}, {63'd0, m_mis});
            chk("mem_req", {63'd0, mif.mem_req}, {63'd0, m_req});
            chk("rdata", {32'd0, rdata}, {32'd0, m_rdata});
`ifdef LSU_TIMEOUT_EN
            chk("timeout", {63'd0, timeout}, {63'd0, m_to});
`endif
            if (m_req) begin
                chk("mem_we", {63'd0, mif.mem_we}, {63'd0, o_we});
                chk("mem_addr", {54'd0, mif.mem_addr}, {54'd0, 10'((o_addr >> 2) & 32'h3FF)});
                chk("mem_be", {60'd0, mif.mem_be}, {60'd0, m_be(o_size, o_addr)});
                chk("mem_wdata", {32'd0, mif.mem_wdata}, {32'd0, m_wrep(o_size, o_wdata)});
            end
            if (done) n_done++;
        end
    end

    // ---------------- directed stimulus ----------------
    int          start_cyc, first_req_cyc, ack_cyc, done_cyc, last_rq, ops_issued;
    bit          saw_req, done_mis;
    logic [3:0]  last_be;
    logic [9:0]  last_addr;
    logic [31:0] last_wd;
    logic        last_we;

    task automatic run_op(input logic w, input logic [1:0] s, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int ack_at, input bit poke);
        int rq = 0;
        bit fin = 0;
        @(posedge clk); #1;
        start = 1; we = w; size = s; sgn = sg; addr = a; wdata = wd; mif.mem_rdata = rd;
        start_cyc = cyc; saw_req = 0; done_mis = 0; ops_issued++;
        @(posedge clk); #1;
        start = 0;
        for (int budget = 0; budget < 40 && !fin; budget++) begin
            mif.mem_ack = 0;
            if (done) begin
                fin = 1; done_cyc = cyc; done_mis = misalign;
            end else if (mif.mem_req) begin
                rq++;
                if (!saw_req) begin
                    saw_req = 1; first_req_cyc = cyc;
                    last_be = mif.mem_be; last_addr = mif.mem_addr;
                    last_wd = mif.mem_wdata; last_we = mif.mem_we;
                end
                if (rq == ack_at) begin mif.mem_ack = 1; ack_cyc = cyc; end
                if (poke && rq == 1) begin start = 1; we = ~w; addr = 32'h7; end
            end
            if (!fin) begin @(posedge clk); #1; start = 0; end
        end
        mif.mem_ack = 0;
        last_rq = rq;
        if (!fin) chk("op_completes", 64'd0, 64'd1);
    endtask

    initial begin
        rst = 0; start = 0; we = 0; size = 0; sgn = 0; addr = 0; wdata = 0;
        mif.mem_ack = 0; mif.mem_rdata = 0; ops_issued = 0;
        #3;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_misalign", {63'd0, misalign}, 64'd0);
        chk("rst_mem_req", {63'd0, mif.mem_req}, 64'd0);
        chk("rst_mem_we", {63'd0, mif.mem_we}, 64'd0);
        chk("rst_mem_be", {60'd0, mif.mem_be}, 64'd0);
        chk("rst_mem_addr", {54'd0, mif.mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mif.mem_wdata}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        @(posedge clk); #1 rst = 1;

        // byte load, sign-extend, ack on 3rd REQ cycle
        run_op(0, 2'd0, 1, 32'h0000_0013, 32'h0, 32'h80FF_1234, 3, 0);
        chk("lb_be", {60'd0, last_be}, 64'h8);
        chk("lb_addr", {54'd0, last_addr}, 64'd4);
        chk("lb_req_latency", 64'(first_req_cyc), 64'(start_cyc + 1));
        chk("lb_req_cycles", 64'(last_rq), 64'd3);
        chk("lb_done_latency", 64'(done_cyc), 64'(ack_cyc + 1));
        chk("lb_rdata", {32'd0, rdata}, 64'hFFFF_FF80);

        // half store, zero wait
        run_op(1, 2'd1, 0, 32'h22, 32'hABCD_5678, 32'hFFFF_FFFF, 1, 0);
        chk("sh_be", {60'd0, last_be}, 64'hC);
        chk("sh_wdata", {32'd0, last_wd}, 64'h5678_5678);
        chk("sh_we", {63'd0, last_we}, 64'd1);
        chk("sh_two_cycle", 64'(done_cyc), 64'(start_cyc + 2));
        chk("sh_rdata_kept", {32'd0, rdata}, 64'hFFFF_FF80);

        run_op(0, 2'd1, 0, 32'h22, 32'h0, 32'h5678_0000, 1, 0);
        chk("lh_rdata", {32'd0, rdata}, 64'h0000_5678);
        run_op(0, 2'd0, 0, 32'h01, 32'h0, 32'h0000_A500, 2, 0);
        chk("lbu_rdata", {32'd0, rdata}, 64'h0000_00A5);
        run_op(0, 2'd1, 1, 32'h00, 32'h0, 32'h1234_8001, 1, 0);
        chk("lhs_rdata", {32'd0, rdata}, 64'hFFFF_8001);
        run_op(0, 2'd2, 1, 32'h10, 32'h0, 32'hDEAD_BEEF, 2, 0);
        chk("lw_be", {60'd0, last_be}, 64'hF);
        chk("lw_rdata", {32'd0, rdata}, 64'hDEAD_BEEF);
        run_op(1, 2'd0, 0, 32'h3, 32'h1234_56AB, 32'h0, 1, 0);
        chk("sb_wdata", {32'd0, last_wd}, 64'hABAB_ABAB);
        chk("sb_be", {60'd0, last_be}, 64'h8);

        // misaligned / illegal accesses
        run_op(0, 2'd2, 0, 32'h6, 32'h0, 32'h5555_5555, 1, 0);
        chk("mis_w_noreq", {63'd0, saw_req}, 64'd0);
        chk("mis_w_flag", {63'd0, done_mis}, 64'd1);
        chk("mis_w_latency", 64'(done_cyc), 64'(start_cyc + 1));
        chk("mis_w_rdata", {32'd0, rdata}, 64'hDEAD_BEEF);
        run_op(0, 2'd3, 0, 32'h8, 32'h0, 32'h5555_5555, 1, 0);
        chk("mis_d_noreq", {63'd0, saw_req}, 64'd0);
        chk("mis_d_flag", {63'd0, done_mis}, 64'd1);
        run_op(0, 2'd1, 0, 32'h3, 32'h0, 32'h5555_5555, 1, 0);
        chk("mis_h_flag", {63'd0, done_mis}, 64'd1);

        // start during REQ and ack in IDLE are ignored
        run_op(0, 2'd2, 0, 32'h40, 32'h0, 32'h0BAD_F00D, 2, 1);
        chk("poke_rdata", {32'd0, rdata}, 64'h0BAD_F00D);
        @(posedge clk); #1 mif.mem_ack = 1; mif.mem_rdata = 32'h1111_1111;
        @(posedge clk); #1 mif.mem_ack = 0;
        repeat (3) @(posedge clk);
        #1 chk("idle_ack_rdata", {32'd0, rdata}, 64'h0BAD_F00D);
        chk("done_count", 64'(n_done), 64'(ops_issued));

`ifdef LSU_TIMEOUT_EN
        run_op(0, 2'd2, 0, 32'h20, 32'h0, 32'h0, 0, 0);
        chk("to_req_cycles", 64'(last_rq), 64'd4);
        chk("to_flag", {63'd0, done_mis}, 64'd1);
`endif

        // asynchronous reset in the middle of a request
        @(posedge clk); #1;
        start = 1; we = 0; size = 2'd2; sgn = 0; addr = 32'h80;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #3;
        chk("pre_rst_req", {63'd0, mif.mem_req}, 64'd1);
        rst = 0; #1;
        chk("async_rst_req", {63'd0, mif.mem_req}, 64'd0);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        chk("post_rst_rdata", {32'd0, rdata}, 64'd0);
        run_op(0, 2'd0, 0, 32'h2, 32'h0, 32'h0033_0000, 1, 0);
        chk("post_rst_load", {32'd0, rdata}, 64'h0000_0033);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
